// File: rtl/dispatch_queue_pkg.sv
// Shared cpu types plus dispatch-queue entry and FSM state.
// Imported by the queue, its pair checker and the bench.
package dispatch_queue_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam int REG_NUM = 32;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic [7:0]       op;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dest;
    logic             use_src1;
    logic             use_src2;
    logic             rf_we;
    logic             is_alu1_op;
    logic             is_alu2_op;
    logic             is_br_op;
    logic             is_mul_div_op;
    logic             is_load_store_op;
  } decoded_inst_t;

  typedef struct packed {
    logic       ex;
    logic [4:0] code;
  } exception_t;

  typedef struct packed {
    virt_t         pc;
    decoded_inst_t inst;
    exception_t    ex;
    logic          store;
    logic          priv;
    logic          eret;
  } dq_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    HOLD
  } dq_state_t;

  function automatic logic dq_is_serial(input dq_entry_t e);
    return e.priv | e.eret | e.ex.ex;
  endfunction

endpackage

// File: rtl/dispatch_queue_pair_check.sv
// Dual-issue pairing rules for head and head+1.
// Purely combinational.
module dq_pair_check
  import dispatch_queue_pkg::*;
(
  input  dq_entry_t i_a,
  input  dq_entry_t i_b,
  output logic      o_can_pair
);

  logic w_raw;
  logic w_md;
  logic w_ls;
  logic w_unused;

  assign w_raw = i_a.inst.rf_we &&
    ((i_b.inst.use_src1 && i_b.inst.src1 == i_a.inst.dest) ||
     (i_b.inst.use_src2 && i_b.inst.src2 == i_a.inst.dest));

  assign w_md = i_a.inst.is_mul_div_op & i_b.inst.is_mul_div_op;
  assign w_ls = i_a.inst.is_load_store_op & i_b.inst.is_load_store_op;

  assign o_can_pair = !dq_is_serial(i_a) && !dq_is_serial(i_b) &&
    !i_b.inst.is_br_op && !w_md && !w_ls && !w_raw;

  assign w_unused = ^{i_a, i_b};

endmodule

// File: rtl/dispatch_queue.sv
// Decoded-instruction queue with in-order dual-issue dispatch.
// Serial entries issue alone against an empty back end.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [1:0]          in_valid,
  input  virt_t [1:0]         in_pc,
  input  decoded_inst_t [1:0] in_inst,
  input  exception_t [1:0]    in_ex,
  input  logic [1:0]          in_store,
  input  logic [1:0]          in_priv,
  input  logic [1:0]          in_eret,
  output logic                in_ready,
  output logic [1:0]          out_valid,
  output virt_t [1:0]         out_pc,
  output decoded_inst_t [1:0] out_inst,
  output exception_t [1:0]    out_ex,
  output logic [1:0]          out_store,
  input  logic [1:0]          out_ready,
  input  logic                commit_empty,
  input  logic                serial_done
);

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_TWO   = (PTR_W+1)'(2);

  dq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  dq_state_t        r_state;
  dq_state_t        w_state_nx;

  dq_entry_t        w_hd0;
  dq_entry_t        w_hd1;
  dq_entry_t        w_new0;
  dq_entry_t        w_new1;
  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;
  logic             w_have1;
  logic             w_have2;
  logic             w_pair;
  logic             w_push0;
  logic             w_push1;
  logic             w_pop0;
  logic             w_pop1;
  logic [1:0]       w_n_push;
  logic [1:0]       w_n_pop;

  assign w_head1 = r_head + 1'b1;
  assign w_tail1 = r_tail + 1'b1;
  assign w_hd0   = r_mem[r_head];
  assign w_hd1   = r_mem[w_head1];
  assign w_have1 = r_count != '0;
  assign w_have2 = r_count >= LP_TWO;

  assign in_ready = (LP_DEPTH - r_count) >= LP_TWO;

  assign w_new0 = '{pc: in_pc[0], inst: in_inst[0], ex: in_ex[0],
                    store: in_store[0], priv: in_priv[0],
                    eret: in_eret[0]};
  assign w_new1 = '{pc: in_pc[1], inst: in_inst[1], ex: in_ex[1],
                    store: in_store[1], priv: in_priv[1],
                    eret: in_eret[1]};

  dq_pair_check u_pair (
    .i_a        (w_hd0),
    .i_b        (w_hd1),
    .o_can_pair (w_pair)
  );

  assign out_pc[0]    = w_hd0.pc;
  assign out_pc[1]    = w_hd1.pc;
  assign out_inst[0]  = w_hd0.inst;
  assign out_inst[1]  = w_hd1.inst;
  assign out_ex[0]    = w_hd0.ex;
  assign out_ex[1]    = w_hd1.ex;
  assign out_store[0] = w_hd0.store;
  assign out_store[1] = w_hd1.store;

  // Issue slot valids and serialization state transitions.
  always_comb begin
    w_state_nx = r_state;
    out_valid  = 2'b00;
    unique case (r_state)
      IDLE: begin
        if (w_have1) begin
          if (dq_is_serial(w_hd0)) begin
            if (commit_empty) begin
              out_valid = 2'b01;
              if (out_ready[0]) w_state_nx = HOLD;
            end else begin
              w_state_nx = DRAIN;
            end
          end else begin
            out_valid = {w_have2 & w_pair, 1'b1};
          end
        end
      end
      DRAIN: if (commit_empty) w_state_nx = IDLE;
      HOLD:  if (serial_done) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_pop0   = out_valid[0] & out_ready[0];
  assign w_pop1   = w_pop0 & out_valid[1] & out_ready[1];
  assign w_push0  = in_ready & in_valid[0];
  assign w_push1  = w_push0 & in_valid[1];
  assign w_n_pop  = {1'b0, w_pop0} + {1'b0, w_pop1};
  assign w_n_push = {1'b0, w_push0} + {1'b0, w_push1};

  // Pointer, occupancy and FSM registers; flush acts as reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= IDLE;
    end else begin
      r_head  <= r_head + PTR_W'(w_n_pop);
      r_tail  <= r_tail + PTR_W'(w_n_push);
      r_count <= r_count + (PTR_W+1)'(w_n_push)
                         - (PTR_W+1)'(w_n_pop);
      r_state <= w_state_nx;
    end
  end

  // Entry payload writes; storage is never cleared.
  always_ff @(posedge clk) begin
    if (w_push0 && !reset && !flush) r_mem[r_tail]  <= w_new0;
    if (w_push1 && !reset && !flush) r_mem[w_tail1] <= w_new1;
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed scenarios then random
// traffic, checked against a queue-based reference model.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int M_RUN = 0;
  localparam int M_WAIT = 1;
  localparam int M_RETIRE = 2;

  logic                clk;
  logic                reset;
  logic                flush;
  logic [1:0]          in_valid;
  virt_t [1:0]         in_pc;
  decoded_inst_t [1:0] in_inst;
  exception_t [1:0]    in_ex;
  logic [1:0]          in_store;
  logic [1:0]          in_priv;
  logic [1:0]          in_eret;
  logic                in_ready;
  logic [1:0]          out_valid;
  virt_t [1:0]         out_pc;
  decoded_inst_t [1:0] out_inst;
  exception_t [1:0]    out_ex;
  logic [1:0]          out_store;
  logic [1:0]          out_ready;
  logic                commit_empty;
  logic                serial_done;

  int n_chk;
  int n_err;
  virt_t r_pc;
  dq_entry_t mq[$];
  int mode;

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_ex        (in_ex),
    .in_store     (in_store),
    .in_priv      (in_priv),
    .in_eret      (in_eret),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_ex       (out_ex),
    .out_store    (out_store),
    .out_ready    (out_ready),
    .commit_empty (commit_empty),
    .serial_done  (serial_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ser(input dq_entry_t e);
    return e.priv || e.eret || e.ex.ex;
  endfunction

  function automatic logic pairs(input dq_entry_t a,
                                 input dq_entry_t b);
    logic raw;
    if (ser(a) || ser(b) || b.inst.is_br_op) return 1'b0;
    if (a.inst.is_mul_div_op && b.inst.is_mul_div_op) return 1'b0;
    if (a.inst.is_load_store_op && b.inst.is_load_store_op)
      return 1'b0;
    raw = a.inst.rf_we &&
      ((b.inst.use_src1 && b.inst.src1 == a.inst.dest) ||
       (b.inst.use_src2 && b.inst.src2 == a.inst.dest));
    return !raw;
  endfunction

  function automatic logic [1:0] exp_valid();
    if (mq.size() == 0 || mode != M_RUN) return 2'b00;
    if (ser(mq[0])) return commit_empty ? 2'b01 : 2'b00;
    if (mq.size() >= 2 && pairs(mq[0], mq[1])) return 2'b11;
    return 2'b01;
  endfunction

  function automatic logic exp_ready();
    return (DEPTH - mq.size()) >= 2;
  endfunction

  function automatic dq_entry_t ent(input int s);
    dq_entry_t e;
    e.pc = in_pc[s];
    e.inst = in_inst[s];
    e.ex = in_ex[s];
    e.store = in_store[s];
    e.priv = in_priv[s];
    e.eret = in_eret[s];
    return e;
  endfunction

  task automatic compare_model();
    logic [1:0] ev;
    ev = exp_valid();
    chk("in_ready", 64'(in_ready), 64'(exp_ready()));
    chk("out_valid", 64'(out_valid), 64'(ev));
    for (int s = 0; s < 2; s++) begin
      if (ev[s]) begin
        chk("out_pc", 64'(out_pc[s]), 64'(mq[s].pc));
        chk("out_inst", 64'(out_inst[s]), 64'(mq[s].inst));
        chk("out_ex", 64'(out_ex[s]), 64'(mq[s].ex));
        chk("out_store", 64'(out_store[s]), 64'(mq[s].store));
      end
    end
  endtask

  task automatic model_step();
    logic [1:0] ev;
    logic rdy;
    int npop;
    if (reset || flush) begin
      mq.delete();
      mode = M_RUN;
      return;
    end
    ev = exp_valid();
    rdy = exp_ready();
    npop = 0;
    if (ev[0] && out_ready[0]) begin
      npop = 1;
      if (ev[1] && out_ready[1]) npop = 2;
    end
    if (mode == M_RUN && mq.size() > 0 && ser(mq[0])) begin
      if (!commit_empty) mode = M_WAIT;
      else if (out_ready[0]) mode = M_RETIRE;
    end else if (mode == M_WAIT && commit_empty) begin
      mode = M_RUN;
    end else if (mode == M_RETIRE && serial_done) begin
      mode = M_RUN;
    end
    for (int i = 0; i < npop; i++) void'(mq.pop_front());
    if (rdy && in_valid[0]) begin
      mq.push_back(ent(0));
      if (in_valid[1]) mq.push_back(ent(1));
    end
  endtask

  task automatic tick(input string tag = "", input int eov = -1);
    #1;
    if (eov >= 0) chk(tag, 64'(out_valid), 64'(eov));
    compare_model();
    model_step();
    @(negedge clk);
  endtask

  function automatic decoded_inst_t alu(input logic [4:0] rd,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    decoded_inst_t d;
    d = '0;
    d.dest = rd;
    d.src1 = rs;
    d.src2 = rt;
    d.use_src1 = 1'b1;
    d.use_src2 = 1'b1;
    d.rf_we = 1'b1;
    d.is_alu1_op = 1'b1;
    return d;
  endfunction

  function automatic decoded_inst_t rnd_inst();
    decoded_inst_t d;
    d = '0;
    d.op = 8'($urandom_range(0, 255));
    d.src1 = REG_W'($urandom_range(0, 3));
    d.src2 = REG_W'($urandom_range(0, 3));
    d.dest = REG_W'($urandom_range(0, 3));
    d.use_src1 = 1'($urandom_range(0, 1));
    d.use_src2 = 1'($urandom_range(0, 1));
    d.rf_we = 1'($urandom_range(0, 1));
    d.is_br_op = ($urandom_range(0, 4) == 0);
    d.is_mul_div_op = ($urandom_range(0, 3) == 0);
    d.is_load_store_op = ($urandom_range(0, 3) == 0);
    d.is_alu1_op = !(d.is_br_op | d.is_mul_div_op |
                     d.is_load_store_op);
    d.is_alu2_op = 1'($urandom_range(0, 1)) & d.is_alu1_op;
    return d;
  endfunction

  task automatic put(input int s, input decoded_inst_t d,
                     input logic pv, input logic er,
                     input logic ex, input logic st);
    in_pc[s] = r_pc;
    r_pc = r_pc + 32'd4;
    in_inst[s] = d;
    in_priv[s] = pv;
    in_eret[s] = er;
    in_ex[s].ex = ex;
    in_ex[s].code = ex ? 5'd12 : 5'd0;
    in_store[s] = st;
  endtask

  task automatic put_rnd(input int s);
    decoded_inst_t d;
    d = rnd_inst();
    put(s, d, ($urandom_range(0, 11) == 0),
        ($urandom_range(0, 19) == 0),
        ($urandom_range(0, 15) == 0),
        d.is_load_store_op & 1'($urandom_range(0, 1)));
  endtask

  initial begin
    decoded_inst_t d0;
    decoded_inst_t d1;
    n_chk = 0;
    n_err = 0;
    r_pc = 32'hbfc0_0000;
    mode = M_RUN;
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 2'b00;
    in_pc = '0;
    in_inst = '0;
    in_ex = '0;
    in_store = '0;
    in_priv = '0;
    in_eret = '0;
    out_ready = 2'b00;
    commit_empty = 1'b1;
    serial_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    put(0, alu(3, 1, 2), 0, 0, 0, 0);
    put(1, alu(4, 1, 2), 0, 0, 0, 0);
    in_valid = 2'b11;
    chk("reset_ready", 64'(in_ready), 64'(1));
    tick("reset_ov", 0);
    in_valid = 2'b00;
    out_ready = 2'b11;
    tick("pair_addu", 3);
    out_ready = 2'b00;
    tick("drained", 0);

    put(0, alu(3, 1, 2), 0, 0, 0, 0);
    put(1, alu(5, 3, 1), 0, 0, 0, 0);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    out_ready = 2'b01;
    tick("raw_single", 1);
    tick("raw_second", 1);
    out_ready = 2'b00;

    commit_empty = 1'b0;
    put(0, '0, 1, 0, 0, 0);
    in_valid = 2'b01;
    tick();
    put(0, alu(6, 1, 2), 0, 0, 0, 0);
    tick("tlb_wait0", 0);
    in_valid = 2'b00;
    tick("tlb_wait1", 0);
    tick("tlb_wait2", 0);
    commit_empty = 1'b1;
    tick("tlb_drain", 0);
    out_ready = 2'b01;
    tick("tlb_issue", 1);
    tick("hold0", 0);
    tick("hold1", 0);
    serial_done = 1'b1;
    tick("hold_done", 0);
    serial_done = 1'b0;
    tick("after_serial", 1);
    out_ready = 2'b00;
    tick("serial_empty", 0);

    in_valid = 2'b01;
    for (int i = 0; i < 7; i++) begin
      put(0, rnd_inst(), 0, 0, 0, 0);
      tick();
    end
    chk("ready_at_7", 64'(in_ready), 64'(0));
    put(0, rnd_inst(), 0, 0, 0, 0);
    put(1, rnd_inst(), 0, 0, 0, 0);
    in_valid = 2'b11;
    tick();
    chk("ready_full_hold", 64'(in_ready), 64'(0));
    out_ready = 2'b11;
    for (int i = 0; i < 9; i++) begin
      put(0, rnd_inst(), 0, 0, 0, 0);
      put(1, rnd_inst(), 0, 0, 0, 0);
      tick();
    end
    in_valid = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    out_ready = 2'b00;
    tick("wrap_empty", 0);

    in_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      put(0, alu(REG_W'(8 + i), 1, 2), 0, 0, 0, 0);
      put(1, alu(REG_W'(12 + i), 1, 2), 0, 0, 0, 0);
      if (i == 2) in_valid = 2'b01;
      tick();
    end
    flush = 1'b1;
    in_valid = 2'b11;
    out_ready = 2'b11;
    put(0, alu(7, 1, 2), 0, 0, 0, 0);
    put(1, alu(9, 1, 2), 0, 0, 0, 0);
    tick("flush_cycle", 3);
    flush = 1'b0;
    in_valid = 2'b00;
    chk("flush_ready", 64'(in_ready), 64'(1));
    tick("flush_ov", 0);
    out_ready = 2'b00;

    d0 = alu(0, 1, 2);
    d0.rf_we = 1'b0;
    d0.is_alu1_op = 1'b0;
    d0.is_mul_div_op = 1'b1;
    d1 = d0;
    d1.src1 = 3;
    d1.src2 = 4;
    put(0, d0, 0, 0, 0, 0);
    put(1, d1, 0, 0, 0, 0);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    flush = 1'b1;
    tick("mult_div", 1);
    flush = 1'b0;

    d0 = alu(5, 1, 0);
    d0.use_src2 = 1'b0;
    d0.is_alu1_op = 1'b0;
    d0.is_load_store_op = 1'b1;
    d1 = alu(0, 2, 6);
    d1.rf_we = 1'b0;
    d1.is_alu1_op = 1'b0;
    d1.is_load_store_op = 1'b1;
    put(0, d0, 0, 0, 0, 0);
    put(1, d1, 0, 0, 0, 1);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    flush = 1'b1;
    tick("lw_sw", 1);
    flush = 1'b0;

    d0 = alu(0, 1, 2);
    d0.rf_we = 1'b0;
    d0.is_alu1_op = 1'b0;
    d0.is_br_op = 1'b1;
    put(0, d0, 0, 0, 0, 0);
    put(1, alu(7, 1, 2), 0, 0, 0, 0);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    flush = 1'b1;
    tick("beq_addu", 3);
    flush = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      put_rnd(0);
      put_rnd(1);
      in_valid = 2'($urandom_range(0, 3));
      out_ready = 2'($urandom_range(0, 3));
      commit_empty = ($urandom_range(0, 3) != 0);
      serial_done = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Decoded-instruction buffer and in-order dual-issue dispatcher, sitting between the decode stage and the functional-unit issue logic.
- Accepts up to two decoded instructions per cycle, with their exception records and side flags, into a circular queue.
- Presents up to two instructions per cycle to issue, applying pairing rules.
- Serializes privileged, eret and excepting instructions against an empty back end.

Parameters:
- DEPTH, 8, queue entries. Must be a power of two and at least 4.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (branch mispredict or exception redirect)
- in_valid  in  2  decoded-slot valid. Legal patterns: 00, 01, 11. Pattern 10 is ignored.
- in_pc  in  2x32  virt_t PC per slot
- in_inst  in  2 x decoded_inst_t  decoded fields per slot
- in_ex  in  2 x exception_t  exception record per slot
- in_store, in_priv, in_eret  in  2 each  per-slot is_store_op, is_privileged_op and is_eret flags
- in_ready  out  1  at least 2 free entries
- out_valid  out  2  issue slot valid
- out_pc, out_inst, out_ex, out_store  out  per slot  head entries (head, head+1)
- out_ready  in  2  issue accepted per slot
- commit_empty  in  1  no instruction in flight past issue
- serial_done  in  1  serialized instruction has retired

Behaviour:
- Reset and flush:
  - Reset: head=tail=0, count=0, FSM=IDLE, out_valid=00, in_ready=1.
  - Flush has the same effect as reset on the next edge and overrides push and pop in that cycle. Entry payloads are not cleared.
- Push:
  - When in_ready && in_valid[0], write slot 0 at tail.
  - If in_valid[1] is also set, write slot 1 at tail+1.
  - tail advances by 1 or 2, wrapping mod DEPTH.
  - in_ready = (DEPTH - count) >= 2, computed from registered count only. It does not depend on this cycle's pop.
- Pop:
  - n_pop = (out_valid[0]&out_ready[0]) + (out_valid[0]&out_ready[0]&out_valid[1]&out_ready[1]).
  - Slot 1 is never taken without slot 0 (in-order issue).
  - count_next = count + n_push - n_pop. Simultaneous push and pop are legal, including at count=DEPTH-2.
- Serial entry:
  - An entry is serial if priv, eret or ex.ex is set.
- FSM:
  - IDLE:
    - If the head is serial: if commit_empty, out_valid=01; otherwise out_valid=00 and go to DRAIN.
    - If the serial head is popped, go to HOLD.
    - If the head is non-serial, normal issue.
  - DRAIN: out_valid=00. When commit_empty=1, go to IDLE; the head issues the next cycle.
  - HOLD: out_valid=00 until serial_done, then go to IDLE.
- out_valid[0] (in IDLE, normal issue) = count>=1.
- out_valid[1] = out_valid[0] && count>=2 && head is not serial, and head+1 meets all of the following:
  - not serial;
  - not is_br_op;
  - not (both is_mul_div_op);
  - not (both is_load_store_op);
  - no RAW: blocked if head.rf_we && ((head+1).use_src1 && src1==head.dest || (head+1).use_src2 && src2==head.dest).
- ALU steering: the output keeps is_alu1_op/is_alu2_op as stored. The issue side re-steers by slot.
- Empty queue: out_valid=00. Full (count>=DEPTH-1): in_ready=0, and no entry is overwritten.
- No combinational path from out_ready to in_ready.

Decomposition:
- decoded_inst_t, exception_t, virt_t and REG_* constants remain in the shared cpu package.
- Add to the package: a dq_entry_t struct {pc, inst, ex, store, priv, eret} and a dq_state_t enum {IDLE, DRAIN, HOLD}.
- One sub-module, dq_pair_check: combinational, takes two dq_entry_t, returns a can_pair flag.

Test Plan:
- Reset, then push 2 ADDU (rd=3, rd=4, rs/rt=1,2) -> next cycle out_valid=11; with out_ready=11, count goes 2->0.
- Push ADDU r3 then ADDU r5,r3,r1 -> out_valid=01 (RAW). After pop, the second issues alone next cycle.
- Push TLBWI with commit_empty=0 for 3 cycles -> out_valid=00 throughout. commit_empty=1 -> out_valid=01. After pop, HOLD until serial_done; the following ADDU issues 1 cycle after serial_done.
- Fill 8 entries with out_ready=00 -> in_ready drops at count=7; in_valid=11 then causes no tail change. Head and tail wrap correctly after 3 drain/refill cycles.
- flush asserted together with push 11 and pop 11 at count=5 -> count=0, out_valid=00, in_ready=1 next cycle.
- Head MULT, head+1 DIV -> out_valid=01. Head LW, head+1 SW -> out_valid=01. Head BEQ, head+1 ADDU -> out_valid=11.
